// File: rtl/sprite_motion_ctrl.sv
// Per-frame direction and shadow position generator for the 4x4 sprite drawer on a 160x120 screen.
// Optional autonomous bounce mode is compiled in with SPRITE_MOTION_BOUNCE_EN.
module sprite_motion_ctrl #(
  parameter logic [7:0] X_START = 8'd78,
  parameter logic [6:0] Y_START = 7'd58,
  parameter logic [7:0] X_MAX   = 8'd156,
  parameter logic [6:0] Y_MAX   = 7'd116
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic [3:0] keys,
  input  logic       mode,
  output logic [7:0] x_start,
  output logic [6:0] y_start,
  output logic [3:0] dir,
  output logic [7:0] x_pos,
  output logic [6:0] y_pos,
  output logic       bump,
  output logic [7:0] bump_count
);

  logic [3:0] key_s1, key_s2;
  logic       tick_d;
  logic       first;
  logic       frame;
  logic       step_r, step_l, step_u, step_d, hit;
  logic       req_r, req_l, req_u, req_d;

  assign x_start = X_START;
  assign y_start = Y_START;
  assign frame   = tick & ~tick_d;

  // Opposing requests cancel before wall checks, so a cancelled pair never bumps.
  assign req_r = key_s2[0] & ~key_s2[3];
  assign req_l = key_s2[3] & ~key_s2[0];
  assign req_u = key_s2[1] & ~key_s2[2];
  assign req_d = key_s2[2] & ~key_s2[1];

`ifdef SPRITE_MOTION_BOUNCE_EN
  logic vx, vy;
  logic vx_nxt, vy_nxt;
  logic flip_x, flip_y;

  always_comb begin
    flip_x = (vx && x_pos == X_MAX) || (!vx && x_pos == 8'd0);
    flip_y = (vy && y_pos == Y_MAX) || (!vy && y_pos == 7'd0);
    vx_nxt = vx ^ flip_x;
    vy_nxt = vy ^ flip_y;
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  always_comb begin
    step_r = req_r && (x_pos != X_MAX);
    step_l = req_l && (x_pos != 8'd0);
    step_d = req_d && (y_pos != Y_MAX);
    step_u = req_u && (y_pos != 7'd0);
    hit    = (req_r && x_pos == X_MAX) || (req_l && x_pos == 8'd0) ||
             (req_d && y_pos == Y_MAX) || (req_u && y_pos == 7'd0);
`ifdef SPRITE_MOTION_BOUNCE_EN
    if (mode) begin
      step_r = vx_nxt;
      step_l = ~vx_nxt;
      step_d = vy_nxt;
      step_u = ~vy_nxt;
      hit    = flip_x | flip_y;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      key_s1     <= 4'd0;
      key_s2     <= 4'd0;
      tick_d     <= 1'b0;
      first      <= 1'b1;
      dir        <= 4'd0;
      x_pos      <= X_START;
      y_pos      <= Y_START;
      bump       <= 1'b0;
      bump_count <= 8'd0;
    end else begin
      key_s1 <= keys;
      key_s2 <= key_s1;
      tick_d <= tick;
      bump   <= 1'b0;
      if (frame) begin
        if (first) begin
          // Drawer loads x_in/y_in on its first update, so no motion this frame.
          first <= 1'b0;
          dir   <= 4'd0;
        end else begin
          dir   <= {step_l, step_d, step_u, step_r};
          x_pos <= x_pos + {7'd0, step_r} - {7'd0, step_l};
          y_pos <= y_pos + {6'd0, step_d} - {6'd0, step_u};
          bump  <= hit;
          if (hit && bump_count != 8'hFF)
            bump_count <= bump_count + 8'd1;
        end
      end
    end
  end

`ifdef SPRITE_MOTION_BOUNCE_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vx <= 1'b1;
      vy <= 1'b1;
    end else if (frame && !first && mode) begin
      vx <= vx_nxt;
      vy <= vy_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: stimulus pushes expected frame results,
// a negedge monitor pops and compares after every frame event and reset release.
module tb_sprite_motion_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] keys = 4'b0001;
  logic       mode = 1'b0;
  logic [7:0] x_start;
  logic [6:0] y_start;
  logic [3:0] dir;
  logic [7:0] x_pos;
  logic [6:0] y_pos;
  logic       bump;
  logic [7:0] bump_count;

  sprite_motion_ctrl dut (
    .clk(clk), .resetn(resetn), .tick(tick), .keys(keys), .mode(mode),
    .x_start(x_start), .y_start(y_start), .dir(dir), .x_pos(x_pos),
    .y_pos(y_pos), .bump(bump), .bump_count(bump_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] d;
    logic [7:0] x;
    logic [6:0] y;
    logic       b;
    logic [7:0] c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ex, ey, ecnt;

  function automatic exp_t mk(input logic [3:0] d, input int x, input int y,
                              input logic b, input int c);
    exp_t e;
    e.d = d; e.x = x[7:0]; e.y = y[6:0]; e.b = b; e.c = c[7:0];
    return e;
  endfunction

  // Monitor
  bit tick_prev = 1'b0;
  bit rst_prev  = 1'b0;
  bit pend      = 1'b0;
  bit chk_bump  = 1'b0;

  task automatic compare(input string name);
    exp_t a, e;
    a = {dir, x_pos, y_pos, bump, bump_count};
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected output dir=%b x=%0d y=%0d bump=%b cnt=%0d",
               name, a.d, a.x, a.y, a.b, a.c);
    end else begin
      e = q.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got dir=%b x=%0d y=%0d bump=%b cnt=%0d, want dir=%b x=%0d y=%0d bump=%b cnt=%0d",
                 name, a.d, a.x, a.y, a.b, a.c, e.d, e.x, e.y, e.b, e.c);
      end
      chk_bump = e.b;
    end
  endtask

  always @(negedge clk) begin
    if (chk_bump && !pend) begin
      chk_bump = 1'b0;
      checks++;
      if (bump !== 1'b0) begin
        errors++;
        $display("FAIL bump_width: bump=%b one cycle after frame, want 0", bump);
      end
    end
    if (pend) compare("frame");
    pend = tick && !tick_prev && resetn;
    if (resetn && !rst_prev) compare("reset");
    tick_prev = tick;
    rst_prev  = resetn;
  end

  // Stimulus helpers
  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_keys(input logic [3:0] k);
    keys = k;
    settle(3);
  endtask

  task automatic do_tick(input exp_t e, input int hold);
    q.push_back(e);
    tick = 1'b1;
    settle(hold);
    tick = 1'b0;
    settle(4);
  endtask

  task automatic do_reset(input int n);
    q.push_back(mk(4'b0000, 78, 58, 1'b0, 0));
    resetn = 1'b0;
    settle(n);
    resetn = 1'b1;
    ex = 78; ey = 58; ecnt = 0;
    settle(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    settle(1);
    do_reset(3);

    // First frame after reset never moves, even with right held.
    do_tick(mk(4'b0000, ex, ey, 1'b0, ecnt), 1);
    ex++;
    do_tick(mk(4'b0001, ex, ey, 1'b0, ecnt), 1);

    set_keys(4'b1101);
    ey++;
    do_tick(mk(4'b0100, ex, ey, 1'b0, ecnt), 1);

    set_keys(4'b0001);
    ex++;
    do_tick(mk(4'b0001, ex, ey, 1'b0, ecnt), 10);

    mode = 1'b1;
`ifdef SPRITE_MOTION_BOUNCE_EN
    ex++; ey++;
    do_tick(mk(4'b0101, ex, ey, 1'b0, ecnt), 1);
`else
    ex++;
    do_tick(mk(4'b0001, ex, ey, 1'b0, ecnt), 1);
`endif
    mode = 1'b0;

    while (ex < 156) begin
      ex++;
      do_tick(mk(4'b0001, ex, ey, 1'b0, ecnt), 1);
    end
    ecnt++;
    do_tick(mk(4'b0000, 156, ey, 1'b1, ecnt), 1);

    set_keys(4'b1000);
    ex--;
    do_tick(mk(4'b1000, ex, ey, 1'b0, ecnt), 1);
    set_keys(4'b0010);
    ey--;
    do_tick(mk(4'b0010, ex, ey, 1'b0, ecnt), 1);
    set_keys(4'b0001);
    ex++;
    do_tick(mk(4'b0001, ex, ey, 1'b0, ecnt), 1);

    // Mid-frame reset while moving right.
    do_reset(1);
    do_tick(mk(4'b0000, 78, 58, 1'b0, 0), 1);

    set_keys(4'b0010);
    while (ey > 0) begin
      ey--;
      do_tick(mk(4'b0010, ex, ey, 1'b0, ecnt), 1);
    end
    for (int i = 0; i < 300; i++) begin
      if (ecnt < 255) ecnt++;
      do_tick(mk(4'b0000, ex, 0, 1'b1, ecnt), 1);
    end

`ifdef SPRITE_MOTION_BOUNCE_EN
    keys = 4'b0101;
    do_reset(2);
    do_tick(mk(4'b0000, 78, 58, 1'b0, 0), 1);
    while (ey < 116) begin
      ex++; ey++;
      do_tick(mk(4'b0101, ex, ey, 1'b0, ecnt), 1);
    end
    set_keys(4'b0001);
    while (ex < 156) begin
      ex++;
      do_tick(mk(4'b0001, ex, ey, 1'b0, ecnt), 1);
    end
    mode = 1'b1;
    do_tick(mk(4'b1010, 155, 115, 1'b1, 1), 1);
    do_tick(mk(4'b1010, 154, 114, 1'b0, 1), 1);
    mode = 1'b0;
`endif

    settle(5);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never observed, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

- Generates the per-frame direction vector (`dir`) and start position consumed by the sprite drawer's `x_in`, `y_in` and `dir_in`.
- Sits directly upstream of the drawer, clocked by the same `clk`.
- Samples player keys, or runs an autonomous bounce pattern, once per slow frame tick.
- Keeps a shadow copy of the sprite's top-left position, so the 4x4 sprite never leaves the 160x120 screen.

## Interface
Parameters:
- X_START, 8'd78: top-left x loaded at reset; drives `x_start`.
- Y_START, 7'd58: top-left y loaded at reset; drives `y_start`.
- X_MAX, 8'd156: largest legal top-left x (160 − 4).
- Y_MAX, 7'd116: largest legal top-left y (120 − 4).

Ports:
- clk  in  1  system clock, same as the drawer and control.
- resetn  in  1  reset, synchronous, active-low.
- tick  in  1  slow frame pulse (`slowClk`); rising edge = new frame.
- keys  in  4  raw requests {left, down, up, right}, active-high, asynchronous.
- mode  in  1  0 = player (keys), 1 = autonomous bounce.
- x_start  out  8  constant X_START, to drawer `x_in`.
- y_start  out  7  constant Y_START, to drawer `y_in`.
- dir  out  4  {left, down, up, right}, to drawer `dir_in`; bit0 = right, bit1 = up, bit2 = down, bit3 = left.
- x_pos  out  8  shadow top-left x after applying `dir`.
- y_pos  out  7  shadow top-left y after applying `dir`.
- bump  out  1  one-cycle pulse when a wall reverses or blocks motion.
- bump_count  out  8  saturating wall-hit count, for the hex display.

## Operation
- **Key sync:** `keys` pass through a 2-FF synchronizer. `tick` is already synchronous; it is edge-detected with a 1-cycle delayed copy.
- **Frame event:** `tick` is 1 and was 0 last cycle. Everything below happens only on a frame event.
- **First frame after reset:** `dir` = 0, `x_pos`/`y_pos` unchanged. This matches the drawer loading `x_in`/`y_in` on its first update.
- **Player mode, per axis:**
  - left and right both set → x component 0.
  - up and down both set → y component 0.
  - right is suppressed when `x_pos` == X_MAX; left when `x_pos` == 0.
  - down is suppressed when `y_pos` == Y_MAX; up when `y_pos` == 0.
  - Any suppressed request raises `bump`.
- **Bounce mode:**
  - Internal velocity bits vx (1 = right, reset 1) and vy (1 = down, reset 1).
  - If the next step on an axis would cross its bound, that axis velocity flips first and the step is taken in the new direction. `bump` is raised.
  - Both axes can flip in the same frame (corner); `bump` still pulses once.
- **Shadow update:** `x_pos` ± 1 and `y_pos` ± 1 per the new `dir`, in the same cycle `dir` updates.
  - Always in range 0..X_MAX and 0..Y_MAX; no wrap-around.
  - Arithmetic is at 8 and 7 bits.
- **Counter:** `bump_count` increments on each `bump` and saturates at 255.
- **Mode switch:** takes effect at the next frame event; vx/vy keep their values.
- **Idle periods:** `dir` holds between frame events. The drawer may sample it at any point in the frame.

## Timing
- **Reset values:** `dir` = 0, `x_pos` = X_START, `y_pos` = Y_START, `bump` = 0, `bump_count` = 0, vx = vy = 1, first-frame flag set, sync/edge registers cleared.
- **Key latency:**
  - A key change is usable 2 clk after it occurs (synchronizer).
  - It is sampled only at the following frame event.
- **Tick latency:** `dir`, `x_pos`, `y_pos` and `bump` update on the clk edge after the cycle in which `tick` rises (1-cycle latency). `bump` is high for exactly that one cycle.
- **Long tick:** `tick` held high for several cycles produces exactly one frame event.
- **Downstream margin:** the drawer's CLEAR phase (≥16 clk) separates `tick` from its UPDATE state, so `dir` is stable before it is consumed.
- **Reset mid-frame:** state returns to reset values at that clk edge. The next frame event is treated as a first frame.
- **Reset vs tick:** reset wins over a coincident tick edge.

## Configuration
- Macro: `SPRITE_MOTION_BOUNCE_EN`.
- **Defined:** bounce mode, vx/vy registers and bounce bump generation are compiled in, as described above.
- **Undefined:**
  - `mode` is ignored; the block is always in player mode.
  - vx/vy are absent.
  - `bump`/`bump_count` report only player wall-blocks.

## Test plan
- **Reset and first frame:** reset, then first tick with right key held → `dir` = 0, `x_pos` = 78, `y_pos` = 58. Second tick → `dir` = 4'b0001, `x_pos` = 79.
- **Opposing keys:** left+right+down held, tick → `dir` = 4'b0100, `y_pos` + 1, `bump` = 0.
- **Wall clamp:** drive to `x_pos` = 156 with right held, tick → `dir` = 0, `x_pos` stays 156, one-cycle `bump`, `bump_count` + 1.
- **Bounce corner (`SPRITE_MOTION_BOUNCE_EN` defined, mode = 1):** reach `x_pos` = 156, `y_pos` = 116 with vx = vy = 1, then tick → `dir` = 4'b1010, `x_pos` = 155, `y_pos` = 115, single `bump`.
- **Tick and counter robustness:**
  - `tick` held high 10 clk → exactly one position step.
  - 300 forced bumps → `bump_count` = 255.
- **Mid-frame reset:** resetn low for 1 clk while `dir` = 4'b0001 → `dir` = 0, positions 78/58, next tick is a first frame with `dir` = 0.
